decoder_scan_ctrl: RTL and testbench
====================================

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- CLK_DIV, 50000, sys_clk cycles each digit is shown (legal range >=2).
- BLANK_CYCLES, 16, sys_clk cycles of all-off guard between digits (legal range >=1).

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- sys_clk, in, 1, single clock for all logic.
- sys_rst, in, 1, synchronous reset, active-high.
- en, in, 1, scan enable.
- digit_mask, in, 8, bit k=1 means digit k takes part in the scan.
- data, in, 32, nibble k (data[4k+3:4k]) is the value shown on digit k.
- sel, out, 3, current digit index; this is the select input of the 3-8 decoder.
- dig_en, out, 8, one-hot decoded digit enable (active-high); all zero when blanked.
- seg_nibble, out, 4, latched nibble for the current digit.
- frame_done, out, 1, one-cycle pulse at the end of each full scan frame.

REQ-003 The clock SHALL be sys_clk and the reset SHALL be sys_rst; there SHALL be one clock only, and the reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, SHOW and BLANK; all outputs SHALL be registered.
REQ-005 IDLE behaviour:
- dig_en=0, frame_done=0.
- sel and seg_nibble hold their previous values.
REQ-006 Leaving IDLE:
- Condition: en=1 and digit_mask!=0.
- The block SHALL latch digit_mask and data into internal frame registers.
- sel <= lowest set mask bit; the next state is SHOW.
REQ-007 SHOW state:
- dig_en = 1<<sel.
- seg_nibble = the latched nibble[sel].
- Duration: exactly CLK_DIV cycles, then BLANK.
REQ-008 BLANK state:
- dig_en=0.
- Duration: exactly BLANK_CYCLES cycles.
- On exit, sel <= next set bit of the latched mask above sel, wrapping modulo 8; the next state is SHOW.
REQ-009 Next-digit search:
- A combinational circular priority search starting at sel+1 (mod 8).
- When the latched mask has a single bit set, the same sel SHALL be reselected.
REQ-010 End of frame:
- Trigger: BLANK exits and the next selected index is <= the current sel (wrap).
- frame_done SHALL pulse high for 1 cycle, coincident with the first SHOW cycle of the new frame.
- digit_mask and data SHALL be re-latched on that same cycle.
- If the new digit_mask is 0, the next state SHALL be IDLE instead of SHOW, and frame_done SHALL still pulse.
REQ-011 Frame registers: data and digit_mask changes mid-frame SHALL NOT affect the frame in progress.
REQ-012 en=0 in SHOW or BLANK:
- The next state SHALL be IDLE with dig_en=0 on the following cycle.
- No frame_done pulse SHALL be produced.
- The prescaler and blank counters SHALL clear.
REQ-013 The prescaler/blank counter SHALL be one shared counter, sized to ceil(log2(max(CLK_DIV, BLANK_CYCLES))) bits, cleared on every state entry.
REQ-014 dig_en SHALL never have more than one bit set; the transition between two digits SHALL always pass through >=1 all-zero cycle.

Reset
REQ-015 While sys_rst=1 at a sys_clk edge, the block SHALL set:
- state=IDLE, sel=0, dig_en=0, seg_nibble=0, frame_done=0.
- counter=0, latched mask=0, latched data=0.
REQ-016 A reset mid-SHOW or mid-BLANK SHALL take effect on the same edge, overriding en and all counters.

Verification (CLK_DIV=4, BLANK_CYCLES=2 unless noted)
REQ-017 Full scan:
- Stimulus: mask=8'hFF, data=32'h76543210, en=1.
- Required response: dig_en walks 01,02,...,80 with 4 cycles on and 2 cycles off each; seg_nibble equals the digit index; frame_done pulses once per 48 cycles, on the return to dig_en=01.
REQ-018 Sparse mask:
- Stimulus: mask=8'b1000_0101.
- Required response: sel sequence 0,2,7,0,...; frame_done on each sel 7->0 transition; no SHOW cycles for the masked digits.
REQ-019 Single digit:
- Stimulus: mask=8'h10.
- Required response: sel stays 4; dig_en toggles 10 (4 cycles) / 00 (2 cycles); frame_done pulses every 6 cycles.
REQ-020 Mid-frame change:
- Stimulus: change data to 32'hFFFFFFFF while sel=3.
- Required response: digits 4-7 still show the old nibbles; the new value appears from digit 0 of the next frame.
REQ-021 Disable and reset:
- Stimulus: drop en during SHOW of digit 5.
- Required response: dig_en=0 on the next cycle, no frame_done; a separate test asserting sys_rst for 1 cycle in BLANK gives all outputs 0 and state IDLE on the next cycle.
REQ-022 Mask cleared:
- Stimulus: set mask=0 mid-frame.
- Required response: the current frame completes normally; frame_done pulses and the block enters IDLE with dig_en=0.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - multiplexed 8-digit scan controller driving a 3-8 decoder select
module decoder_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [7:0]  digit_mask,
  input  logic [31:0] data,
  output logic [2:0]  sel,
  output logic [7:0]  dig_en,
  output logic [3:0]  seg_nibble,
  output logic        frame_done
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [7:0]     mask_q;
  logic [31:0]    data_q;
  logic [2:0]     sel_q;
  logic [7:0]     dig_en_q;
  logic [3:0]     seg_q;
  logic           frame_done_q;

  logic [2:0]     first_sel_d;
  logic [2:0]     next_sel_d;
  logic           wrap_d;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Circular search from sel+1; the last candidate (offset 8) is sel itself,
  // so a single-bit mask reselects the same digit and counts as a wrap.
  always_comb begin
    next_sel_d = sel_q;
    for (int i = 8; i >= 1; i--) begin
      if (mask_q[3'(sel_q + 3'(i))]) next_sel_d = 3'(sel_q + 3'(i));
    end
    wrap_d      = (next_sel_d <= sel_q);
    first_sel_d = lowest_bit(digit_mask);
  end

  always_ff @(posedge sys_clk) begin
    frame_done_q <= 1'b0;
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      dig_en_q <= '0;
      seg_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          dig_en_q <= '0;
          cnt_q    <= '0;
          if (en && digit_mask != 8'h00) begin
            mask_q   <= digit_mask;
            data_q   <= data;
            sel_q    <= first_sel_d;
            seg_q    <= data[{first_sel_d, 2'b00} +: 4];
            dig_en_q <= 8'h01 << first_sel_d;
            state_q  <= SHOW;
          end
        end
        SHOW: begin
          if (!en) begin
            state_q  <= IDLE;
            dig_en_q <= '0;
            cnt_q    <= '0;
          end else if (cnt_q == CW'(CLK_DIV - 1)) begin
            state_q  <= BLANK;
            dig_en_q <= '0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BLANK: begin
          if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
            cnt_q <= '0;
            if (wrap_d) begin
              // Frame boundary: take a fresh snapshot and restart from its lowest digit.
              frame_done_q <= 1'b1;
              mask_q       <= digit_mask;
              data_q       <= data;
              if (digit_mask == 8'h00) begin
                state_q <= IDLE;
              end else begin
                sel_q    <= first_sel_d;
                seg_q    <= data[{first_sel_d, 2'b00} +: 4];
                dig_en_q <= 8'h01 << first_sel_d;
                state_q  <= SHOW;
              end
            end else begin
              sel_q    <= next_sel_d;
              seg_q    <= data_q[{next_sel_d, 2'b00} +: 4];
              dig_en_q <= 8'h01 << next_sel_d;
              state_q  <= SHOW;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          dig_en_q <= '0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign dig_en     = dig_en_q;
  assign seg_nibble = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - self-checking bench for decoder_scan_ctrl against a frame-schedule model
module tb_decoder_scan_ctrl;

  localparam int CLK_DIV      = 4;
  localparam int BLANK_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  mask = 8'h00;
  logic [31:0] data = 32'h0;
  logic [2:0]  sel;
  logic [7:0]  dig_en;
  logic [3:0]  seg_nibble;
  logic        frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  decoder_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .en         (en),
    .digit_mask (mask),
    .data       (data),
    .sel        (sel),
    .dig_en     (dig_en),
    .seg_nibble (seg_nibble),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] dig;
    logic [3:0] seg;
    logic       fd;
  } slot_t;

  slot_t      m_q[$];
  bit         m_run = 1'b0;
  logic [2:0] e_sel = 3'd0;
  logic [7:0] e_dig = 8'h00;
  logic [3:0] e_seg = 4'h0;
  logic       e_fd  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A frame is the list of every output cycle: each enabled digit shown, then blanked.
  task automatic build(input logic [7:0] m, input logic [31:0] d, input logic fd0);
    logic f;
    f = fd0;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        for (int c = 0; c < CLK_DIV; c++) begin
          m_q.push_back({3'(k), 8'(8'h01 << k), d[4*k +: 4], f});
          f = 1'b0;
        end
        for (int c = 0; c < BLANK_CYCLES; c++)
          m_q.push_back({3'(k), 8'h00, d[4*k +: 4], 1'b0});
      end
    end
  endtask

  task automatic pop();
    slot_t s;
    s = m_q.pop_front();
    e_sel = s.sel;
    e_dig = s.dig;
    e_seg = s.seg;
    e_fd  = s.fd;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_run = 1'b0;
      m_q.delete();
      e_sel = 3'd0; e_dig = 8'h00; e_seg = 4'h0; e_fd = 1'b0;
    end else if (m_run && !en) begin
      m_run = 1'b0;
      m_q.delete();
      e_dig = 8'h00; e_fd = 1'b0;
    end else if (m_run) begin
      if (m_q.size() == 0) begin
        if (mask == 8'h00) begin
          m_run = 1'b0;
          e_dig = 8'h00; e_fd = 1'b1;
        end else begin
          build(mask, data, 1'b1);
          pop();
        end
      end else begin
        pop();
      end
    end else if (en && mask != 8'h00) begin
      build(mask, data, 1'b0);
      m_run = 1'b1;
      pop();
    end else begin
      e_dig = 8'h00; e_fd = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("sel", 32'(sel), 32'(e_sel));
    chk("dig_en", 32'(dig_en), 32'(e_dig));
    chk("seg_nibble", 32'(seg_nibble), 32'(e_seg));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("onehot", 32'($countones(dig_en) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(3);

    // Full scan over all eight digits.
    mask = 8'hFF; data = 32'h76543210; en = 1'b1;
    run(110);

    // Sparse and single-digit masks.
    mask = 8'b1000_0101;
    run(70);
    mask = 8'h10;
    run(40);

    // Data change while digit 3 is shown must not touch the rest of this frame.
    mask = 8'hFF; data = 32'h76543210;
    for (int i = 0; i < 120; i++) begin
      if (e_sel == 3'd3 && e_dig == 8'h08) break;
      step();
    end
    chk("reach_sel3", 32'(sel), 32'd3);
    data = 32'hFFFFFFFF;
    run(110);

    // Drop enable while digit 5 is shown.
    data = 32'h76543210;
    for (int i = 0; i < 120; i++) begin
      if (e_dig == 8'h20) break;
      step();
    end
    chk("reach_dig5", 32'(dig_en), 32'h20);
    en = 1'b0;
    step();
    chk("en_drop_dig", 32'(dig_en), 32'h0);
    chk("en_drop_fd", 32'(frame_done), 32'h0);
    run(4);
    en = 1'b1;

    // One-cycle reset during a blank gap.
    for (int i = 0; i < 60; i++) begin
      if (m_run && e_dig == 8'h00) break;
      step();
    end
    chk("reach_blank", 32'(dig_en), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_all_zero", {20'h0, sel, dig_en, seg_nibble, frame_done}, 32'h0);
    run(20);

    // Clearing the mask lets the current frame finish and then idles.
    mask = 8'hFF;
    run(60);
    mask = 8'h00;
    for (int i = 0; i < 80; i++) begin
      if (!m_run) break;
      step();
    end
    chk("mask0_idle", 32'(dig_en), 32'h0);
    run(10);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      en  = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 29) == 0)
        mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        data = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
